bus_err_addr_tracker: RTL and testbench
=======================================

Name: bus_err_addr_tracker

Overview:
Per-ID request-address tracker and error-event capture stage, fed by per-ID request and response handshake strobes.
- Stores each request's address in a per-channel FIFO.
- Matches in-order responses against that FIFO.
- On an error response, emits one registered error record (address, code, channel) on a valid/ready stream. A downstream error logger and register file consumes the stream.

Parameters:
AddrWidth, 32, request address width
ErrBits, 2, response error field width; bits [1:0] are the AXI resp, upper bits are user error bits
NumChannels, 4, number of independent ID channels
NumOutstanding, 4, FIFO depth per channel; must be >= 1

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
req_hs_valid_i  in  NumChannels  one-hot request handshake per channel
req_addr_i  in  AddrWidth  address of the current request handshake
rsp_hs_valid_i  in  NumChannels  response beat handshake per channel
rsp_burst_last_i  in  NumChannels  response beat is the last of its burst
rsp_err_i  in  ErrBits  error field of the current response beat
err_valid_o  out  1  error record valid
err_ready_i  in  1  consumer accepts the record
err_addr_o  out  AddrWidth  request address of the erroring transaction
err_code_o  out  ErrBits  error field of the first erroring beat
err_chan_o  out  $clog2(NumChannels) (min 1)  channel index
err_drop_o  out  1  single-cycle pulse: an error record was lost
proto_err_o  out  1  sticky: push to full FIFO, or response on empty FIFO

Behaviour:
- Reset: all FIFOs empty; all burst_err_seen bits cleared; err_valid_o=0; err_addr_o, err_code_o, err_chan_o = 0; err_drop_o=0; proto_err_o=0. Reset mid-burst discards all state.
- Error definition: rsp_err_i[1]=1, or any bit above bit 1 nonzero. EXOKAY (01) with zero user bits is not an error.
- Push: req_hs_valid_i[c] writes req_addr_i into FIFO c.
  - Full FIFO with no pop on channel c in the same cycle: address dropped, proto_err_o set.
  - Full FIFO with a same-cycle pop on channel c: the push is accepted.
- Pop: rsp_hs_valid_i[c] & rsp_burst_last_i[c] removes the head of FIFO c.
- Empty FIFO: any rsp_hs_valid_i[c] on an empty FIFO sets proto_err_o; no pop, no error record. A push in the same cycle does not satisfy that response.
- Error capture:
  - An erroring beat on channel c with burst_err_seen[c]=0 creates a candidate {head address of c, rsp_err_i, c}.
  - burst_err_seen[c] is set unless the beat is also last.
  - Further errors in the same burst are suppressed.
  - burst_err_seen[c] clears on the last beat.
- Multiple channels erroring in the same cycle: the lowest index wins; each loser pulses err_drop_o.
- Output register (single entry), latency 1: an error handshake in cycle N gives err_valid_o=1 in cycle N+1.
  - Load when empty, or when err_ready_i=1 in the same cycle.
  - Otherwise the candidate is dropped and err_drop_o pulses in cycle N+1.
  - Output fields are stable while err_valid_o=1 and err_ready_i=0.
- FIFO pointers wrap modulo NumOutstanding. The occupancy counter has width $clog2(NumOutstanding+1).

Optional Feature:
BUS_ERR_ADDR_TRACKER_DROP_CNT_EN
- Defined: adds output err_drop_cnt_o [7:0], a saturating count of dropped records (saturates at 255, reset 0), and input err_drop_clr_i. When clear and increment coincide, the count becomes 1.
- Undefined: no port and no counter; err_drop_o only.

Decomposition:
- Shared package bus_err_pkg holds:
  - err_rec_t struct {addr, code, chan}.
  - Function is_err(code).
  - Constant ChanIdxWidth.
- Sub-module bus_err_addr_fifo: one per channel via generate. Contains storage, read/write pointers, count, full/empty, and head output.

Test Plan:
- Ch1 push 0x1000 then 0x2000; ch1 single-beat SLVERR (10) last -> cycle+1 err_valid_o=1, err_addr_o=0x1000, err_code_o=2, err_chan_o=1; next ch1 OKAY pops 0x2000 with no record.
- 4-beat read on ch0 (addr 0x80), beats 2 and 3 DECERR -> exactly one record {0x80, 3, 0}; the next ch0 burst error is captured normally.
- err_ready_i held 0 with a record pending; second error on ch2 -> err_drop_o pulses once, pending record unchanged; raise ready -> record consumed.
- Fill ch3 with NumOutstanding=4 pushes, then a 5th push with a same-cycle last beat on ch3 -> accepted, proto_err_o stays 0; a 6th push without pop -> proto_err_o=1.
- Response on empty ch2 -> proto_err_o=1, no err_valid_o; EXOKAY (01) with zero user bits on ch0 -> no record.
- Assert rst_ni low mid-burst with a record pending -> all outputs return to reset values asynchronously; the FIFOs are empty after release.

Source files
------------

// File: rtl/bus_err_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bus_err_pkg
// Purpose  : Shared configuration, error-record type and error classifier for
//            the bus error address tracker and its per-channel FIFOs.
// Contents : Cfg* configuration constants, ChanIdxWidth, err_rec_t, is_err().
// Revision : 1.0 - initial release
// ============================================================================
package bus_err_pkg;

  // Configuration the error record type is built from. The tracker's
  // parameters default to these values and must stay consistent with them.
  localparam int unsigned CfgAddrWidth      = 32;
  localparam int unsigned CfgErrBits        = 2;
  localparam int unsigned CfgNumChannels    = 4;
  localparam int unsigned CfgNumOutstanding = 4;

  // A single channel still needs a one-bit index field.
  localparam int unsigned ChanIdxWidth =
      (CfgNumChannels > 1) ? $clog2(CfgNumChannels) : 1;

  typedef struct packed {
    logic [CfgAddrWidth-1:0] addr;
    logic [CfgErrBits-1:0]   code;
    logic [ChanIdxWidth-1:0] chan;
  } err_rec_t;

  // Bit 1 covers SLVERR/DECERR; EXOKAY (01) is a success. Any user bit above
  // the AXI resp field also marks the beat as erroring.
  function automatic logic is_err(input logic [CfgErrBits-1:0] code);
    return code[1] | ((code >> 2) != '0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bus_err_addr_fifo.sv
`default_nettype none
// ============================================================================
// Module   : bus_err_addr_fifo
// Purpose  : Request-address FIFO for one ID channel. Push and pop must be
//            pre-qualified by the caller (no push when full unless a pop
//            happens in the same cycle, no pop when empty).
// Ports    : clk, rst_n (async, active-low)
//            push, wdata     - write an address at the tail
//            pop             - drop the head entry
//            head            - current head address
//            full, empty     - occupancy flags
// Revision : 1.0 - initial release
// ============================================================================
module bus_err_addr_fifo #(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [Width-1:0] wdata,
  output logic [Width-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntWidth = $clog2(Depth + 1);

  logic [Width-1:0]    mem [Depth];
  logic [PtrWidth-1:0] wr_ptr;
  logic [PtrWidth-1:0] rd_ptr;
  logic [CntWidth-1:0] count;

  // Pointers wrap at Depth, which need not be a power of two.
  function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
    return (p == PtrWidth'(Depth - 1)) ? '0 : p + PtrWidth'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CntWidth'(1);
        2'b01:   count <= count - CntWidth'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked entirely by count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == CntWidth'(Depth));
  assign empty = (count == '0);

endmodule
`default_nettype wire

// File: rtl/bus_err_addr_tracker.sv
`default_nettype none
// ============================================================================
// Module   : bus_err_addr_tracker
// Purpose  : Per-ID request address tracking with error-event capture. Each
//            request address is queued per channel; in-order responses are
//            matched to the queue head and the first erroring beat of a burst
//            produces one registered error record on a valid/ready stream.
// Ports    : clk_i, rst_ni (async, active-low)
//            req_hs_valid_i/req_addr_i     - one-hot request handshake + addr
//            rsp_hs_valid_i/rsp_burst_last_i/rsp_err_i - response beats
//            err_valid_o/err_ready_i, err_addr_o/err_code_o/err_chan_o
//                                          - error record stream
//            err_drop_o  - one-cycle pulse when a record is lost
//            proto_err_o - sticky protocol violation flag
// Option   : `define BUS_ERR_ADDR_TRACKER_DROP_CNT_EN adds err_drop_clr_i and
//            err_drop_cnt_o (8-bit saturating drop counter).
// Revision : 1.0 - initial release
// ============================================================================
module bus_err_addr_tracker
  import bus_err_pkg::*;
#(
  parameter int unsigned AddrWidth      = CfgAddrWidth,
  parameter int unsigned ErrBits        = CfgErrBits,
  parameter int unsigned NumChannels    = CfgNumChannels,
  parameter int unsigned NumOutstanding = CfgNumOutstanding
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NumChannels-1:0]  req_hs_valid_i,
  input  logic [AddrWidth-1:0]    req_addr_i,
  input  logic [NumChannels-1:0]  rsp_hs_valid_i,
  input  logic [NumChannels-1:0]  rsp_burst_last_i,
  input  logic [ErrBits-1:0]      rsp_err_i,
  output logic                    err_valid_o,
  input  logic                    err_ready_i,
  output logic [AddrWidth-1:0]    err_addr_o,
  output logic [ErrBits-1:0]      err_code_o,
  output logic [ChanIdxWidth-1:0] err_chan_o,
  output logic                    err_drop_o,
`ifdef BUS_ERR_ADDR_TRACKER_DROP_CNT_EN
  input  logic                    err_drop_clr_i,
  output logic [7:0]              err_drop_cnt_o,
`endif
  output logic                    proto_err_o
);

  logic [NumChannels-1:0] fifo_empty;
  logic [NumChannels-1:0] fifo_full;
  logic [AddrWidth-1:0]   fifo_head [NumChannels];
  logic [NumChannels-1:0] push_ok;
  logic [NumChannels-1:0] pop_ok;
  logic [NumChannels-1:0] proto_hit;
  logic [NumChannels-1:0] cand;
  logic [NumChannels-1:0] burst_err_seen;
  logic                   beat_is_err;

  err_rec_t               win_rec;
  logic                   win_any;
  logic                   multi_cand;
  logic                   load_ok;
  logic                   drop_next;
  err_rec_t               rec;

  assign beat_is_err = is_err(rsp_err_i);

  generate
    for (genvar c = 0; c < NumChannels; c++) begin : g_chan
      // A pop needs a non-empty FIFO; a same-cycle push never satisfies it.
      assign pop_ok[c]  = rsp_hs_valid_i[c] & rsp_burst_last_i[c] & ~fifo_empty[c];
      // A full FIFO still accepts the push if its head leaves this cycle.
      assign push_ok[c] = req_hs_valid_i[c] & (~fifo_full[c] | pop_ok[c]);

      assign proto_hit[c] = (rsp_hs_valid_i[c] & fifo_empty[c]) |
                            (req_hs_valid_i[c] & fifo_full[c] & ~pop_ok[c]);

      // Only the first erroring beat of a burst with a matching request counts.
      assign cand[c] = rsp_hs_valid_i[c] & ~fifo_empty[c] & beat_is_err &
                       ~burst_err_seen[c];

      bus_err_addr_fifo #(
        .Width (AddrWidth),
        .Depth (NumOutstanding)
      ) u_fifo (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .push  (push_ok[c]),
        .pop   (pop_ok[c]),
        .wdata (req_addr_i),
        .head  (fifo_head[c]),
        .full  (fifo_full[c]),
        .empty (fifo_empty[c])
      );

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          burst_err_seen[c] <= 1'b0;
        end else if (rsp_hs_valid_i[c] && !fifo_empty[c]) begin
          if (rsp_burst_last_i[c]) begin
            burst_err_seen[c] <= 1'b0;
          end else if (beat_is_err) begin
            burst_err_seen[c] <= 1'b1;
          end
        end
      end
    end
  endgenerate

  // Scan from the top down so the lowest erroring channel is assigned last.
  always_comb begin
    win_rec = '0;
    win_any = 1'b0;
    for (int c = int'(NumChannels) - 1; c >= 0; c--) begin
      if (cand[c]) begin
        win_any      = 1'b1;
        win_rec.addr = fifo_head[c];
        win_rec.code = rsp_err_i;
        win_rec.chan = ChanIdxWidth'(c);
      end
    end
  end

  // More than one candidate bit set means at least one loser.
  assign multi_cand = |(cand & (cand - NumChannels'(1)));
  assign load_ok    = ~err_valid_o | err_ready_i;
  assign drop_next  = multi_cand | (win_any & ~load_ok);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rec         <= '0;
      err_valid_o <= 1'b0;
      err_drop_o  <= 1'b0;
      proto_err_o <= 1'b0;
    end else begin
      err_drop_o <= drop_next;
      if (|proto_hit) proto_err_o <= 1'b1;
      if (win_any && load_ok) begin
        err_valid_o <= 1'b1;
        rec         <= win_rec;
      end else if (err_ready_i) begin
        err_valid_o <= 1'b0;
      end
    end
  end

  assign err_addr_o = rec.addr;
  assign err_code_o = rec.code;
  assign err_chan_o = rec.chan;

`ifdef BUS_ERR_ADDR_TRACKER_DROP_CNT_EN
  // Counts alongside the err_drop_o pulse; a clear that coincides with a drop
  // restarts the count at one.
  logic [7:0] drop_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      drop_cnt <= 8'd0;
    end else if (err_drop_clr_i) begin
      drop_cnt <= drop_next ? 8'd1 : 8'd0;
    end else if (drop_next && drop_cnt != 8'hFF) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end

  assign err_drop_cnt_o = drop_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bus_err_addr_tracker.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_err_addr_tracker
// Purpose  : Self-checking bench for bus_err_addr_tracker: directed scenarios
//            followed by randomized traffic, compared every cycle against a
//            queue-based transaction model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bus_err_addr_tracker;

  localparam int NC = 4;
  localparam int NO = 4;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [3:0]  req_hs_valid_i;
  logic [31:0] req_addr_i;
  logic [3:0]  rsp_hs_valid_i;
  logic [3:0]  rsp_burst_last_i;
  logic [1:0]  rsp_err_i;
  logic        err_ready_i;
  logic        err_valid_o;
  logic [31:0] err_addr_o;
  logic [1:0]  err_code_o;
  logic [1:0]  err_chan_o;
  logic        err_drop_o;
  logic        proto_err_o;
`ifdef BUS_ERR_ADDR_TRACKER_DROP_CNT_EN
  logic        err_drop_clr_i = 1'b0;
  logic [7:0]  err_drop_cnt_o;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  bus_err_addr_tracker dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .req_hs_valid_i   (req_hs_valid_i),
    .req_addr_i       (req_addr_i),
    .rsp_hs_valid_i   (rsp_hs_valid_i),
    .rsp_burst_last_i (rsp_burst_last_i),
    .rsp_err_i        (rsp_err_i),
    .err_valid_o      (err_valid_o),
    .err_ready_i      (err_ready_i),
    .err_addr_o       (err_addr_o),
    .err_code_o       (err_code_o),
    .err_chan_o       (err_chan_o),
    .err_drop_o       (err_drop_o),
`ifdef BUS_ERR_ADDR_TRACKER_DROP_CNT_EN
    .err_drop_clr_i   (err_drop_clr_i),
    .err_drop_cnt_o   (err_drop_cnt_o),
`endif
    .proto_err_o      (proto_err_o)
  );

  // ---------------- transaction-level reference model ----------------
  logic [31:0] mq [NC][$];
  bit          m_seen [NC];
  bit          m_v, m_drop, m_proto;
  logic [31:0] m_addr;
  logic [1:0]  m_code, m_chan;

  // SLVERR (10) and DECERR (11) are errors; OKAY and EXOKAY are not.
  function automatic bit ref_is_err(input logic [1:0] e);
    return (e == 2'b10) || (e == 2'b11);
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NC; c++) begin
      mq[c].delete();
      m_seen[c] = 1'b0;
    end
    m_v = 0; m_drop = 0; m_proto = 0;
    m_addr = '0; m_code = '0; m_chan = '0;
  endtask

  task automatic model_update(input logic [3:0] req, input logic [31:0] addr,
                              input logic [3:0] rsp, input logic [3:0] last,
                              input logic [1:0] err, input logic ready);
    int          ncand = 0;
    bit          have = 0;
    bit          drop = 0;
    logic [31:0] waddr = '0;
    logic [1:0]  wchan = '0;
    for (int c = 0; c < NC; c++) begin
      if (rsp[c]) begin
        if (mq[c].size() == 0) begin
          m_proto = 1;
        end else begin
          if (ref_is_err(err) && !m_seen[c]) begin
            ncand++;
            if (!have) begin
              have  = 1;
              waddr = mq[c][0];
              wchan = 2'(c);
            end
          end
          if (last[c])              m_seen[c] = 0;
          else if (ref_is_err(err)) m_seen[c] = 1;
        end
      end
    end
    for (int c = 0; c < NC; c++) begin
      bit pop  = rsp[c] && last[c] && (mq[c].size() > 0);
      bit full = (mq[c].size() >= NO);
      if (req[c] && full && !pop) m_proto = 1;
      if (pop) void'(mq[c].pop_front());
      if (req[c] && (!full || pop)) mq[c].push_back(addr);
    end
    if (ncand > 1) drop = 1;
    if (have) begin
      if (!m_v || ready) begin
        m_v = 1; m_addr = waddr; m_code = err; m_chan = wchan;
      end else begin
        drop = 1;
      end
    end else if (ready) begin
      m_v = 0;
    end
    m_drop = drop;
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("err_valid", 64'(err_valid_o), 64'(m_v));
    chk("err_addr",  64'(err_addr_o),  64'(m_addr));
    chk("err_code",  64'(err_code_o),  64'(m_code));
    chk("err_chan",  64'(err_chan_o),  64'(m_chan));
    chk("err_drop",  64'(err_drop_o),  64'(m_drop));
    chk("proto_err", 64'(proto_err_o), 64'(m_proto));
  endtask

  // One clock: inputs already applied are captured, the edge happens, the
  // model advances with the same inputs, and the outputs are compared.
  task automatic cycle();
    logic [3:0]  r  = req_hs_valid_i;
    logic [31:0] a  = req_addr_i;
    logic [3:0]  s  = rsp_hs_valid_i;
    logic [3:0]  l  = rsp_burst_last_i;
    logic [1:0]  e  = rsp_err_i;
    logic        rd = err_ready_i;
    @(posedge clk_i);
    #1;
    model_update(r, a, s, l, e, rd);
    check_all();
  endtask

  task automatic idle();
    req_hs_valid_i   = '0;
    req_addr_i       = '0;
    rsp_hs_valid_i   = '0;
    rsp_burst_last_i = '0;
    rsp_err_i        = '0;
  endtask

  task automatic push(input int ch, input logic [31:0] addr);
    idle();
    req_hs_valid_i[ch] = 1'b1;
    req_addr_i         = addr;
    cycle();
  endtask

  task automatic beat(input int ch, input logic last, input logic [1:0] err);
    idle();
    rsp_hs_valid_i[ch]   = 1'b1;
    rsp_burst_last_i[ch] = last;
    rsp_err_i            = err;
    cycle();
  endtask

  task automatic sync_reset();
    idle();
    rst_ni = 1'b0;
    model_reset();
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    check_all();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_ni      = 1'b0;
    err_ready_i = 1'b1;
    idle();
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    check_all();
    chk("reset_valid", 64'(err_valid_o), 64'd0);
    rst_ni = 1'b1;
    cycle();

    // Single-beat SLVERR on ch1 captures the first queued address.
    err_ready_i = 1'b0;
    push(1, 32'h1000);
    push(1, 32'h2000);
    beat(1, 1'b1, 2'b10);
    chk("t1_valid", 64'(err_valid_o), 64'd1);
    chk("t1_addr",  64'(err_addr_o),  64'h1000);
    chk("t1_code",  64'(err_code_o),  64'd2);
    chk("t1_chan",  64'(err_chan_o),  64'd1);
    err_ready_i = 1'b1;
    beat(1, 1'b1, 2'b00);
    chk("t1_okay_no_rec", 64'(err_valid_o), 64'd0);

    // Four-beat burst on ch0 with two DECERR beats yields one record.
    push(0, 32'h80);
    beat(0, 1'b0, 2'b00);
    beat(0, 1'b0, 2'b11);
    chk("t2_rec_valid", 64'(err_valid_o), 64'd1);
    chk("t2_rec_addr",  64'(err_addr_o),  64'h80);
    chk("t2_rec_code",  64'(err_code_o),  64'd3);
    beat(0, 1'b0, 2'b11);
    chk("t2_suppressed", 64'(err_valid_o), 64'd0);
    beat(0, 1'b1, 2'b00);
    push(0, 32'h90);
    beat(0, 1'b1, 2'b11);
    chk("t2_next_burst", 64'(err_addr_o), 64'h90);

    // Pending record blocks a second error on ch2, which is dropped.
    idle();
    cycle();
    err_ready_i = 1'b0;
    push(2, 32'hA0);
    push(1, 32'hB0);
    beat(1, 1'b1, 2'b10);
    beat(2, 1'b1, 2'b10);
    chk("t3_drop_pulse", 64'(err_drop_o), 64'd1);
    chk("t3_hold_addr",  64'(err_addr_o), 64'hB0);
    idle();
    cycle();
    chk("t3_drop_once", 64'(err_drop_o), 64'd0);
    err_ready_i = 1'b1;
    cycle();
    chk("t3_consumed", 64'(err_valid_o), 64'd0);

    // Full ch3 accepts a push alongside a pop but not without one.
    for (int i = 0; i < NO; i++) push(3, 32'h300 + 32'(i) * 32'h10);
    idle();
    req_hs_valid_i[3]   = 1'b1;
    req_addr_i          = 32'h340;
    rsp_hs_valid_i[3]   = 1'b1;
    rsp_burst_last_i[3] = 1'b1;
    cycle();
    chk("t4_push_pop_ok", 64'(proto_err_o), 64'd0);
    push(3, 32'h350);
    chk("t4_overflow", 64'(proto_err_o), 64'd1);
    for (int i = 0; i < NO; i++) beat(3, 1'b1, 2'b00);

    // Response on empty ch2 and EXOKAY on ch0.
    sync_reset();
    beat(2, 1'b0, 2'b00);
    chk("t5_empty_proto", 64'(proto_err_o), 64'd1);
    chk("t5_empty_norec", 64'(err_valid_o), 64'd0);
    push(0, 32'h50);
    beat(0, 1'b1, 2'b01);
    chk("t5_exokay", 64'(err_valid_o), 64'd0);

    // Asynchronous reset mid-burst with a record pending.
    err_ready_i = 1'b0;
    push(1, 32'h60);
    beat(1, 1'b0, 2'b10);
    chk("t6_pending", 64'(err_valid_o), 64'd1);
    idle();
    #2;
    rst_ni = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("t6_async_proto", 64'(proto_err_o), 64'd0);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    err_ready_i = 1'b1;
    beat(1, 1'b1, 2'b00);
    chk("t6_fifo_empty", 64'(proto_err_o), 64'd1);
    push(1, 32'h70);
    beat(1, 1'b1, 2'b10);
    chk("t6_capture", 64'(err_addr_o), 64'h70);

    // Randomized traffic against the model.
    sync_reset();
    for (int n = 0; n < 600; n++) begin
      int unsigned r = $urandom_range(0, 6);
      idle();
      if (r < 4) begin
        req_hs_valid_i[r] = 1'b1;
        req_addr_i        = $urandom;
      end
      rsp_hs_valid_i   = 4'($urandom & $urandom);
      rsp_burst_last_i = 4'($urandom);
      rsp_err_i        = 2'($urandom_range(0, 3));
      err_ready_i      = ($urandom_range(0, 3) != 0);
      cycle();
      if (n == 300) sync_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
